// File: rtl/pose_pixel_source.sv
// Pixel compositor and round sequencer feeding the scoring block.
// Walks an H_ACTIVE x V_ACTIVE raster on pix_valid, merges the player and
// template masks into 12-bit RGB, flags the scoring frame of each round, and
// pulses update on that frame's last pixel. All outputs are registered.
module pose_pixel_source #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int ROUND_FRAMES = 4,
  parameter int NUM_ROUNDS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pix_valid,
  input  logic        player_mask,
  input  logic        template_mask,
  output logic [11:0] pixel,
  output logic        pix_out_valid,
  output logic        counting,
  output logic        update,
  output logic [7:0]  round,
  output logic        busy,
  output logic        done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int FW = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;

  // LAST is the single cycle between the song's final pixel and DONE: the
  // final pixel's output (with update) is still on the wire, and any
  // pix_valid arriving then must not be counted against a new round.
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

  state_t         state, state_nxt;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [FW-1:0]  f;
  logic           line_end, frame_end, score, last_round, take, restart, song_end;
  logic [11:0]    comp;

  assign line_end   = (x == XW'(H_ACTIVE - 1));
  assign frame_end  = line_end && (y == YW'(V_ACTIVE - 1));
  assign score      = (f == FW'(ROUND_FRAMES - 1));
  assign last_round = (round == 8'(NUM_ROUNDS - 1));
  assign take       = (state == RUN) && pix_valid;
  assign restart    = ((state == IDLE) || (state == DONE)) && start;
  assign song_end   = take && frame_end && score && last_round;

  // Overlay colour from the (player, template) mask pair.
  always_comb begin
    comp = 12'h000;
    case ({player_mask, template_mask})
      2'b11:   comp = 12'hFF0;
      2'b01:   comp = 12'hF00;
      2'b10:   comp = 12'h0F0;
      default: comp = 12'h000;
    endcase
  end

  // Next-state logic; start is only honoured outside RUN/LAST.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (song_end) state_nxt = LAST;
      LAST:    state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, with busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == LAST);
      done  <= (state_nxt == DONE);
    end
  end

  // Raster/frame/round counters and the registered pixel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      f             <= '0;
      round         <= 8'd0;
      pixel         <= 12'h000;
      pix_out_valid <= 1'b0;
      counting      <= 1'b0;
      update        <= 1'b0;
    end else begin
      pixel         <= 12'h000;
      pix_out_valid <= 1'b0;
      counting      <= 1'b0;
      update        <= 1'b0;
      if (restart) begin
        x     <= '0;
        y     <= '0;
        f     <= '0;
        round <= 8'd0;
      end else if (take) begin
        pixel         <= comp;
        pix_out_valid <= 1'b1;
        counting      <= score;
        update        <= frame_end && score;
        if (line_end) begin
          x <= '0;
          if (frame_end) begin
            y <= '0;
            f <= score ? '0 : f + 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
      // Round advances the cycle after update, except after the last round.
      if (state == RUN && update && !last_round)
        round <= round + 8'd1;
    end
  end

endmodule

// File: tb/tb_pose_pixel_source.sv
// Directed bench for pose_pixel_source with a 4x2 raster, 4 frames/round,
// 2 rounds/song: 8 pixels/frame, 32/round, 64/song.
module tb_pose_pixel_source;

  logic        clk = 1'b0;
  logic        reset, start, pix_valid, player_mask, template_mask;
  logic [11:0] pixel;
  logic        pix_out_valid, counting, update, busy, done;
  logic [7:0]  round;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pose_pixel_source #(.H_ACTIVE(4), .V_ACTIVE(2), .ROUND_FRAMES(4), .NUM_ROUNDS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid),
    .player_mask(player_mask), .template_mask(template_mask), .pixel(pixel),
    .pix_out_valid(pix_out_valid), .counting(counting), .update(update),
    .round(round), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the active edge.
  task automatic step(input logic pv, input logic pm, input logic tm, input logic st);
    @(negedge clk);
    pix_valid = pv; player_mask = pm; template_mask = tm; start = st;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_pix(input logic pm, input logic tm);
    if (pm && tm) return 12'hFF0;
    if (tm)       return 12'hF00;
    if (pm)       return 12'h0F0;
    return 12'h000;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".pixel"},    pixel, 12'h000);
    chk({tag, ".pov"},      pix_out_valid, 1'b0);
    chk({tag, ".counting"}, counting, 1'b0);
    chk({tag, ".update"},   update, 1'b0);
  endtask

  // Present counted pixel k of the song (0..63); masks cycle 00,10,01,11.
  task automatic pix_k(input int k, input logic st);
    logic pm, tm;
    int   r;
    pm = (k % 2) == 1;
    tm = ((k / 2) % 2) == 1;
    r  = k % 32;
    step(1'b1, pm, tm, st);
    chk($sformatf("pixel[%0d]", k),    pixel, exp_pix(pm, tm));
    chk($sformatf("pov[%0d]", k),      pix_out_valid, 1'b1);
    chk($sformatf("counting[%0d]", k), counting, (r >= 24) ? 1'b1 : 1'b0);
    chk($sformatf("update[%0d]", k),   update, (r == 31) ? 1'b1 : 1'b0);
    chk($sformatf("round[%0d]", k),    round, k / 32);
    chk($sformatf("busy[%0d]", k),     busy, 1'b1);
    chk($sformatf("done[%0d]", k),     done, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_quiet("gap");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; player_mask = 1'b0; template_mask = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_quiet("rst");
    chk("rst.round", round, 8'd0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    reset = 1'b0;

    // IDLE ignores pix_valid.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk_quiet("idle");
      chk("idle.busy", busy, 1'b0);
    end

    // Start with a coincident pixel: that pixel is dropped.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_quiet("start");
    chk("start.busy", busy, 1'b1);
    chk("start.round", round, 8'd0);

    // Round 0 continuous, then round 1 with random gaps and a start mid-run.
    for (int k = 0; k < 32; k++) pix_k(k, 1'b0);
    for (int k = 32; k < 64; k++) begin
      if ($urandom_range(0, 2) == 0) gap();
      pix_k(k, (k == 40) ? 1'b1 : 1'b0);
    end

    // Next cycle: DONE takes effect, round holds at last value.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_quiet("done0");
    chk("done0.done", done, 1'b1);
    chk("done0.busy", busy, 1'b0);
    chk("done0.round", round, 8'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk_quiet("done");
      chk("done.round", round, 8'd1);
    end

    // Restart from DONE.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk_quiet("restart");
    chk("restart.done", done, 1'b0);
    chk("restart.busy", busy, 1'b1);
    chk("restart.round", round, 8'd0);
    for (int k = 0; k < 28; k++) pix_k(k, 1'b0);

    // Reset arrives on pixel 28 inside the scoring frame.
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk_quiet("midrst");
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.done", done, 1'b0);
    chk("midrst.round", round, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk_quiet("postrst");
    end

    // Fresh song starts at round 0, frame 0.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rerun.busy", busy, 1'b1);
    for (int k = 0; k < 34; k++) pix_k(k, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
